// File: rtl/ps2_phy_if.sv
// ps2_phy upper-side bundle: command write strobe
// and received-byte / status signals.
interface ps2_phy_if;
  logic       write;
  logic [7:0] tx_data;
  logic       read;
  logic [7:0] rx_data;
  logic       busy;
  logic       error;

  modport master (
    output write, tx_data,
    input  read, rx_data, busy, error
  );

  modport slave (
    input  write, tx_data,
    output read, rx_data, busy, error
  );
endinterface

// File: rtl/ps2_phy.sv
// ps2_phy: PS/2 host line controller, open-drain
// clk/data, 11-bit frame RX and host command TX.
module ps2_phy #(
  parameter int FILTER_LEN     = 8,
  parameter int INHIBIT_CYCLES = 1200,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        ps2_clk,
  inout  wire        ps2_data,
  ps2_phy_if.slave   bus
);

  localparam int TW =
    $clog2(TIMEOUT_CYCLES + INHIBIT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  localparam logic [TW-1:0] TMO =
    TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] INH_LAST =
    TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] INH_DAT =
    TW'(INHIBIT_CYCLES - 2);
  localparam logic [FW-1:0] FLT_LAST =
    FW'(FILTER_LEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RX    = 3'd1;
  localparam logic [2:0] S_INH   = 3'd2;
  localparam logic [2:0] S_BITS  = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          tmo;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [3:0]    bit_cnt;
  logic [7:0]    rx_shift;
  logic          rx_par;
  logic [7:0]    tx_shift;
  logic          tx_par;
  logic          clk_oe;
  logic          data_oe;

  assign ps2_clk  = clk_oe  ? 1'b0 : 1'bz;
  assign ps2_data = data_oe ? 1'b0 : 1'bz;

  assign bus.busy = (state != S_IDLE);

  assign fall = filt_clk & ~clk_s2 &
                (filt_cnt == FLT_LAST);
  assign tmo  = (timer == TMO);

  // two-flop synchronisers for both pins
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // clock glitch filter: level follows a run of
  // FILTER_LEN differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FLT_LAST) begin
      filt_clk <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // frame sequencer, line drivers and watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_par      <= 1'b0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      clk_oe      <= 1'b0;
      data_oe     <= 1'b0;
      bus.read    <= 1'b0;
      bus.error   <= 1'b0;
      bus.rx_data <= '0;
    end else begin
      bus.read  <= 1'b0;
      bus.error <= 1'b0;
      case (state)
        S_IDLE: begin
          timer   <= '0;
          bit_cnt <= '0;
          if (fall) begin
            if (!dat_s2) state <= S_RX;
          end else if (bus.write) begin
            tx_shift <= bus.tx_data;
            tx_par   <= ~^bus.tx_data;
            clk_oe   <= 1'b1;
            state    <= S_INH;
          end
        end
        S_RX: begin
          if (fall) begin
            timer   <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < 4'd8) begin
              rx_shift <= {dat_s2, rx_shift[7:1]};
            end else if (bit_cnt == 4'd8) begin
              rx_par <= dat_s2;
            end else begin
              if ((^{rx_shift, rx_par}) && dat_s2) begin
                bus.rx_data <= rx_shift;
                bus.read    <= 1'b1;
              end else begin
                bus.error <= 1'b1;
              end
              state <= S_IDLE;
            end
          end else if (tmo) begin
            bus.error <= 1'b1;
            state     <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_INH: begin
          timer <= timer + 1'b1;
          if (timer == INH_DAT) data_oe <= 1'b1;
          if (timer == INH_LAST) begin
            clk_oe  <= 1'b0;
            timer   <= '0;
            bit_cnt <= '0;
            state   <= S_BITS;
          end
        end
        S_BITS: begin
          if (fall) begin
            timer   <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < 4'd8) begin
              data_oe <= ~tx_shift[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              data_oe <= ~tx_par;
            end else begin
              data_oe <= 1'b0;
              state   <= S_ACK;
            end
          end else if (tmo) begin
            bus.error <= 1'b1;
            data_oe   <= 1'b0;
            clk_oe    <= 1'b0;
            state     <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_ACK: begin
          if (fall) begin
            timer     <= '0;
            bus.error <= dat_s2;
            state     <= S_WAIT;
          end else if (tmo) begin
            bus.error <= 1'b1;
            data_oe   <= 1'b0;
            clk_oe    <= 1'b0;
            state     <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT: begin
          if (filt_clk && dat_s2) begin
            state <= S_IDLE;
          end else if (tmo) begin
            bus.error <= 1'b1;
            data_oe   <= 1'b0;
            clk_oe    <= 1'b0;
            state     <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_phy.sv
// tb_ps2_phy: directed bench with a PS/2 device
// model on pulled-up open-drain lines.
`timescale 1ns/1ps
module tb_ps2_phy;

  localparam int FL  = 8;
  localparam int INH = 1200;
  localparam int TMO = 24000;

  `define CHK(tag, obs, exp) \
    begin \
      checks++; \
      assert ((obs) === (exp)) else begin \
        failures++; \
        $error("FAIL %s observed=%0h expected=%0h", \
               tag, (obs), (exp)); \
      end \
    end

  logic clk = 1'b0;
  logic reset;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  wire  ps2_clk_w;
  wire  ps2_data_w;

  pullup (ps2_clk_w);
  pullup (ps2_data_w);

  assign ps2_clk_w  = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_data_w = dev_dat_low ? 1'b0 : 1'bz;

  ps2_phy_if bus ();

  ps2_phy #(
    .FILTER_LEN     (FL),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk_w),
    .ps2_data (ps2_data_w),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   read_cnt = 0;
  int   err_cnt = 0;
  int   clk_low_cnt = 0;
  time  read_t, err_t, fall_t;
  logic read_busy;
  logic busy_all;

  // output monitor, sampled away from the rising edge
  always @(negedge clk) begin
    if (bus.read === 1'b1) begin
      read_cnt++;
      read_t    = $time;
      read_busy = bus.busy;
    end
    if (bus.error === 1'b1) begin
      err_cnt++;
      err_t = $time;
    end
    if (ps2_clk_w === 1'b0) clk_low_cnt++;
  end

  task automatic send_frame(input logic [10:0] b,
                            input int h,
                            input int n);
    busy_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      dev_dat_low = ~b[i];
      repeat (h) @(negedge clk);
      dev_clk_low = 1'b1;
      fall_t = $time;
      repeat (h) @(negedge clk);
      if (i < 10) busy_all = busy_all & bus.busy;
      dev_clk_low = 1'b0;
    end
    repeat (h) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic pulse_write(input logic [7:0] v);
    @(negedge clk);
    bus.write   = 1'b1;
    bus.tx_data = v;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic measure_inhibit(output int n,
                                 output logic dl,
                                 output logic dp);
    n  = 0;
    dl = 1'b1;
    dp = 1'b1;
    while (ps2_clk_w === 1'b0 && n < 5000) begin
      dp = dl;
      dl = ps2_data_w;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic dev_tx(input logic ack,
                        input int h,
                        output logic [10:0] got);
    got = '0;
    repeat (h) @(negedge clk);
    got[0] = ps2_data_w;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (h) @(negedge clk);
      got[i] = ps2_data_w;
      dev_clk_low = 1'b0;
      repeat (h) @(negedge clk);
    end
    if (ack) dev_dat_low = 1'b1;
    repeat (h) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (h) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (h) @(negedge clk);
    dev_dat_low = 1'b0;
    repeat (h) @(negedge clk);
  endtask

  initial begin
    int          r0, e0, c0, n, lat, k;
    logic        dl, dp;
    logic [10:0] got;

    reset       = 1'b1;
    bus.write   = 1'b0;
    bus.tx_data = 8'h00;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);

    `CHK("rst_read", bus.read, 1'b0)
    `CHK("rst_error", bus.error, 1'b0)
    `CHK("rst_busy", bus.busy, 1'b0)
    `CHK("rst_rx_data", bus.rx_data, 8'h00)
    `CHK("rst_clk_pin", ps2_clk_w, 1'b1)
    `CHK("rst_data_pin", ps2_data_w, 1'b1)

    // good frame 0x1C at 12.5 kHz
    r0 = read_cnt;
    e0 = err_cnt;
    send_frame({1'b1, 1'b0, 8'h1C, 1'b0}, 480, 11);
    repeat (100) @(negedge clk);
    lat = int'((read_t - fall_t) / 10);
    `CHK("rx1c_reads", read_cnt - r0, 1)
    `CHK("rx1c_errors", err_cnt - e0, 0)
    `CHK("rx1c_data", bus.rx_data, 8'h1C)
    `CHK("rx1c_latency_ok",
         (lat >= FL + 2 && lat <= FL + 4), 1'b1)
    `CHK("rx1c_busy_frame", busy_all, 1'b1)
    `CHK("rx1c_busy_at_read", read_busy, 1'b0)

    // 0xAA with wrong parity
    r0 = read_cnt;
    e0 = err_cnt;
    send_frame({1'b1, 1'b0, 8'hAA, 1'b0}, 200, 11);
    repeat (100) @(negedge clk);
    `CHK("rxaa_errors", err_cnt - e0, 1)
    `CHK("rxaa_reads", read_cnt - r0, 0)
    `CHK("rxaa_data_kept", bus.rx_data, 8'h1C)

    // host command 0xF4, device acks
    e0 = err_cnt;
    pulse_write(8'hF4);
    measure_inhibit(n, dl, dp);
    `CHK("txf4_inhibit_len", n, INH)
    `CHK("txf4_start_low", dl, 1'b0)
    `CHK("txf4_start_late", dp, 1'b1)
    pulse_write(8'h00);
    dev_tx(1'b1, 200, got);
    repeat (50) @(negedge clk);
    `CHK("txf4_bits", got, 11'b10111101000)
    `CHK("txf4_errors", err_cnt - e0, 0)
    `CHK("txf4_busy_end", bus.busy, 1'b0)
    `CHK("txf4_clk_rel", ps2_clk_w, 1'b1)
    `CHK("txf4_data_rel", ps2_data_w, 1'b1)

    // host command 0xF4, device never acks
    e0 = err_cnt;
    pulse_write(8'hF4);
    measure_inhibit(n, dl, dp);
    `CHK("nack_inhibit_len", n, INH)
    dev_tx(1'b0, 200, got);
    repeat (50) @(negedge clk);
    `CHK("nack_bits", got, 11'b10111101000)
    `CHK("nack_errors", err_cnt - e0, 1)
    `CHK("nack_busy_end", bus.busy, 1'b0)
    `CHK("nack_clk_rel", ps2_clk_w, 1'b1)
    `CHK("nack_data_rel", ps2_data_w, 1'b1)

    // frame abandoned after 4 bits
    r0 = read_cnt;
    e0 = err_cnt;
    send_frame({1'b1, 1'b0, 8'h29, 1'b0}, 200, 4);
    k = 0;
    while (err_cnt == e0 && k < TMO + 2000) begin
      @(negedge clk);
      k++;
    end
    lat = int'((err_t - fall_t) / 10);
    `CHK("tmo_errors", err_cnt - e0, 1)
    `CHK("tmo_latency_ok",
         (lat >= TMO + FL + 2 && lat <= TMO + FL + 4),
         1'b1)
    `CHK("tmo_reads", read_cnt - r0, 0)
    repeat (5) @(negedge clk);
    `CHK("tmo_busy", bus.busy, 1'b0)

    r0 = read_cnt;
    send_frame({1'b1, 1'b0, 8'h29, 1'b0}, 200, 11);
    repeat (100) @(negedge clk);
    `CHK("rx29_reads", read_cnt - r0, 1)
    `CHK("rx29_data", bus.rx_data, 8'h29)

    // reset during inhibit, write while busy
    e0 = err_cnt;
    pulse_write(8'h5A);
    repeat (100) @(negedge clk);
    `CHK("inh_clk_low", ps2_clk_w, 1'b0)
    `CHK("inh_busy", bus.busy, 1'b1)
    pulse_write(8'h00);
    reset = 1'b1;
    @(negedge clk);
    `CHK("mrst_clk_rel", ps2_clk_w, 1'b1)
    `CHK("mrst_data_rel", ps2_data_w, 1'b1)
    `CHK("mrst_busy", bus.busy, 1'b0)
    `CHK("mrst_read", bus.read, 1'b0)
    `CHK("mrst_error", bus.error, 1'b0)
    `CHK("mrst_rx_data", bus.rx_data, 8'h00)
    reset = 1'b0;
    c0 = clk_low_cnt;
    repeat (1500) @(negedge clk);
    `CHK("mrst_no_activity", clk_low_cnt - c0, 0)
    `CHK("mrst_no_error", err_cnt - e0, 0)
    `CHK("mrst_idle_busy", bus.busy, 1'b0)

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_phy.md
# ps2_phy

PS/2 host-side line controller: drives the open-drain `ps2_clk`/`ps2_data` pair, deserialises device-to-host frames and serialises host-to-device command bytes. It sits directly below the keyboard scan-code decoder. It hands each received byte up as a one-cycle `read` strobe and accepts single-byte commands (e.g. 0xF4 enable) through a `write` strobe. All timing is counted in `clk` cycles; the lines are never driven high.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronised samples required before the filtered `ps2_clk` changes level.
- `INHIBIT_CYCLES`, 1200: host clock-inhibit duration before a transmit (100 µs at 12 MHz).
- `TIMEOUT_CYCLES`, 24000: maximum gap between falling edges inside a frame (2 ms at 12 MHz).

- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high.
- `ps2_clk`  inout  1  open-drain: driven 0 or released (`z`).
- `ps2_data`  inout  1  open-drain: driven 0 or released (`z`).
- `write`  input  1  one-cycle request to transmit `tx_data`.
- `tx_data`  input  8  command byte; sampled only on an accepted `write`.
- `read`  output  1  one-cycle strobe: `rx_data` holds a valid byte.
- `rx_data`  output  8  last good received byte; held until the next good frame.
- `busy`  output  1  high whenever state ≠ IDLE.
- `error`  output  1  one-cycle strobe on a parity, start, stop, ack or timeout failure.

## Operation
- Input path: 2-FF synchroniser on both pins, then the FILTER_LEN glitch filter on the clock. A falling edge of the filtered clock is the bit event, and the synchronised data is sampled at that event.
- The frame is 11 bits: start=0, D0..D7 LSB first, odd parity, stop=1.
- States: IDLE, RX, TX_INHIBIT, TX_BITS, TX_ACK, TX_WAIT.
- IDLE to RX: on a falling edge with data=0. A falling edge with data=1 is ignored.
- RX: shift 8 data bits, then parity, then stop.
  - After the stop bit, if parity is odd and stop=1: load `rx_data`, pulse `read`.
  - Otherwise pulse `error` and leave `rx_data` unchanged.
  - In both cases return to IDLE.
- IDLE to TX_INHIBIT: on `write`=1 with no falling edge in the same cycle. Latch `tx_data` and compute odd parity, then drive `ps2_clk` low for INHIBIT_CYCLES.
  - In the last inhibit cycle, drive `ps2_data` low (start bit).
  - Next cycle: release `ps2_clk` and enter TX_BITS.
- TX_BITS: data stays low until the first device falling edge.
  - Falling edges 1–8 present D0..D7. A 1 means release, a 0 means drive low.
  - Edge 9 presents parity. Edge 10 releases data (stop).
  - Then enter TX_ACK.
- TX_ACK: at the next falling edge, sample data.
  - 0: ack OK.
  - 1: pulse `error`.
  - Either way, enter TX_WAIT.
- TX_WAIT: stay until filtered clock and synchronised data are both 1, then go to IDLE.
- Watchdog: in RX, TX_BITS, TX_ACK or TX_WAIT, if a gap exceeds TIMEOUT_CYCLES without a falling edge (or, in TX_WAIT, without lines idle):
  - pulse `error`, release both lines, go to IDLE;
  - a partially received byte is discarded.
- `write` while `busy`=1 is ignored; there is no queue.
- If `write` and a start-bit falling edge arrive in the same IDLE cycle, RX wins and the write is dropped.

## Timing
- Reset values: `read`=0, `error`=0, `busy`=0, `rx_data`=0x00, both lines released, state IDLE, counters 0.
- Reset mid-frame: lines are released in the same cycle `reset` is sampled and the frame is abandoned without an `error` pulse.
- `read`/`error` are exactly one cycle wide.
  - `read` rises FILTER_LEN+3 cycles (±1, constant per build) after the 11th pin falling edge.
  - `rx_data` is valid in the same cycle.
- `busy` rises the cycle after the start edge or the accepted `write`. It falls in the cycle IDLE is re-entered, which is the same cycle as `read`/`error`.
- `ps2_clk` inhibit lasts exactly INHIBIT_CYCLES. `ps2_data` goes low 1 cycle before `ps2_clk` is released.
- TX bit changes occur FILTER_LEN+3 cycles (±1) after each device falling edge, well inside the ~40 µs clock-low phase.
- Parity is the XOR of the 8 data bits, inverted.

## Test plan
- RX 0x1C (parity 0, stop 1) at 12.5 kHz device clock -> one `read` pulse, `rx_data`=0x1C, `busy` high for the whole frame, no `error`.
- RX 0xAA with parity bit 0 (wrong) -> `error` pulse, no `read`, `rx_data` keeps its previous value.
- `write`=1, `tx_data`=0xF4 in IDLE, device model clocks and acks -> `ps2_clk` low for 1200 cycles; data line shows 0,0,0,1,0,1,1,1,1,0 (start, D0..D7, parity 0); stop released; no `error`; then IDLE.
- TX 0xF4 with device not acking (data high at edge 11) -> `error` pulse, lines released, `busy` falls after lines idle.
- RX aborted after 4 bits, clock then stays high -> `error` exactly TIMEOUT_CYCLES+1 cycles after the last edge, then IDLE. A following full 0x29 frame then gives `read` with `rx_data`=0x29.
- `reset` pulse during TX_INHIBIT, and `write` pulsed while `busy` -> both lines released the same cycle and all outputs at reset values; the write while busy produces no line activity.
